jt12_mux_demux: RTL and testbench

Receiver end of the FM accumulator's multiplexed DAC stream. It consumes the time-multiplexed 9-bit mux_left/mux_right words, one channel per mux_sample strobe. From each frame it rebuilds per-channel stereo samples and a summed stereo mix. It sits between the FM core's mux output and the board audio path, so the mix can be taken without the core's combined accumulator, and individual channels can be read back or muted for debug.

---
 rtl/jt12_mux_pkg.sv | 30 +++
 rtl/jt12_mux_demux_if.sv | 33 +++
 rtl/jt12_mux_acc.sv | 71 +++++++
 rtl/jt12_mux_demux.sv | 167 ++++++++++++++++
 tb/tb_jt12_mux_demux.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jt12_mux_pkg.sv
// ----------------------------------------------------------------------------
// jt12_mux_pkg
// Shared constants and types for the JT12 multiplexed-DAC receiver.
//   CH     : channel slots per frame
//   W      : width of each multiplexed signed word
//   OW     : width of the summed stereo mix
//   ERRW   : width of the saturating frame-error counter
//   SLOT_W : width of the slot counter
//   SEL_W  : width of the readback slot select
// ----------------------------------------------------------------------------
package jt12_mux_pkg;

    localparam int CH     = 6;
    localparam int W      = 9;
    localparam int OW     = 12;
    localparam int ERRW   = 8;
    localparam int SLOT_W = $clog2(CH);
    localparam int SEL_W  = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The mix cannot overflow when the output has room for CH full-scale words.
    function automatic bit ow_fits(input int ow, input int w, input int ch);
        return ow >= (w + $clog2(ch));
    endfunction

endpackage

// File: rtl/jt12_mux_demux_if.sv
// ----------------------------------------------------------------------------
// jt12_mux_demux_if
// Stream bundle between the FM core's multiplexed output and the receiver.
//   sync       : frame alignment pulse (source -> receiver)
//   mux_sample : word-valid strobe (source -> receiver)
//   mux_left   : signed left word of the current slot
//   mux_right  : signed right word of the current slot
//   left/right : signed mixed stereo output (receiver -> consumer)
//   sample     : mix-updated pulse (receiver -> consumer)
// master = stream source / mix consumer, slave = receiver.
// ----------------------------------------------------------------------------
interface jt12_mux_demux_if #(
    parameter int DW = jt12_mux_pkg::W,
    parameter int MW = jt12_mux_pkg::OW
);
    logic          sync;
    logic          mux_sample;
    logic [DW-1:0] mux_left;
    logic [DW-1:0] mux_right;
    logic [MW-1:0] left;
    logic [MW-1:0] right;
    logic          sample;

    modport master (
        output sync, mux_sample, mux_left, mux_right,
        input  left, right, sample
    );

    modport slave (
        input  sync, mux_sample, mux_left, mux_right,
        output left, right, sample
    );
endinterface

// File: rtl/jt12_mux_acc.sv
// ----------------------------------------------------------------------------
// jt12_mux_acc
// One side (left or right) of the frame mixer: accumulates sign-extended
// words across a frame, commits the total to the output on the last slot.
//   clk, rst : clock, synchronous active-high reset
//   clk_en   : clock enable; nothing changes while low
//   clear    : realign; the running sum is discarded before any add
//   add      : a word is accepted this cycle
//   last     : the accepted word is the final slot of the frame
//   mute     : the accepted word is excluded from the sum (still counted)
//   word     : signed input word
//   mix      : signed committed frame sum
// ----------------------------------------------------------------------------
module jt12_mux_acc
    import jt12_mux_pkg::*;
#(
    parameter int IW  = W,
    parameter int AW  = OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          clear,
    input  logic          add,
    input  logic          last,
    input  logic          mute,
    input  logic [IW-1:0] word,
    output logic [AW-1:0] mix
);

    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] mix_q, mix_d;
    logic [AW-1:0] word_ext;
    logic [AW-1:0] base;
    logic [AW-1:0] sum;

    always_comb begin
        word_ext = mute ? '0 : {{(AW-IW){word[IW-1]}}, word};
        // A realign coinciding with a word starts a fresh frame with that word.
        base     = clear ? '0 : acc_q;
        sum      = base + word_ext;

        acc_d = acc_q;
        mix_d = mix_q;
        if (clk_en) begin
            if (add) begin
                if (last) begin
                    mix_d = sum;
                    acc_d = '0;
                end else begin
                    acc_d = sum;
                end
            end else if (clear) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            mix_q <= '0;
        end else begin
            acc_q <= acc_d;
            mix_q <= mix_d;
        end
    end

    assign mix = mix_q;

endmodule

// File: rtl/jt12_mux_demux.sv
// ----------------------------------------------------------------------------
// jt12_mux_demux
// Receiver for the FM accumulator's time-multiplexed DAC stream. Rebuilds
// per-slot stereo words and a summed stereo mix once per frame.
//   clk, rst  : clock, synchronous active-high reset
//   clk_en    : clock enable; all state advances only when high
//   bus       : stream in (sync, mux_sample, mux_left/right), mix out
//               (left, right, sample)
//   mute      : per-slot mute mask for the mix
//   ch_sel    : readback slot select; values >= CH read zero
//   ch_left   : stored left word of slot ch_sel
//   ch_right  : stored right word of slot ch_sel
//   locked    : high while aligned (RUN)
//   err       : pulse, a partial frame was discarded
//   err_cnt   : saturating count of discarded frames
//
// state | meaning
// ------+----------------------------------------------------------
// HUNT  | not aligned; words ignored until the first sync
// RUN   | aligned; words land in slot order, frame committed at CH-1
// ----------------------------------------------------------------------------
module jt12_mux_demux
    import jt12_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    jt12_mux_demux_if.slave   bus,
    input  logic [CH-1:0]     mute,
    input  logic [SEL_W-1:0]  ch_sel,
    output logic [W-1:0]      ch_left,
    output logic [W-1:0]      ch_right,
    output logic              locked,
    output logic              err,
    output logic [ERRW-1:0]   err_cnt
);

    if (!ow_fits(OW, W, CH)) begin : g_ow_check
        $error("jt12_mux_demux: OW too narrow for CH words of W bits");
    end

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                sample_q, sample_d;
    logic                err_q, err_d;
    logic [ERRW-1:0]     err_cnt_q, err_cnt_d;
    logic [W-1:0]        ch_l_q [CH];
    logic [W-1:0]        ch_l_d [CH];
    logic [W-1:0]        ch_r_q [CH];
    logic [W-1:0]        ch_r_d [CH];

    logic                run;
    logic [SLOT_W-1:0]   slot_eff;
    logic                accept;
    logic                frame_last;
    logic                partial;
    logic                mute_bit;

    // Sync is applied before the word of the same cycle, so that word is slot 0.
    always_comb begin
        run        = (state_q == RUN);
        slot_eff   = bus.sync ? '0 : slot_q;
        accept     = bus.mux_sample && (run || bus.sync);
        frame_last = (slot_eff == SLOT_W'(CH-1));
        partial    = run && bus.sync && (slot_q != '0);
        mute_bit   = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (slot_eff == SLOT_W'(i)) mute_bit = mute[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        sample_d  = sample_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        ch_l_d    = ch_l_q;
        ch_r_d    = ch_r_q;

        if (clk_en) begin
            sample_d = accept && frame_last;
            err_d    = partial;

            if (bus.sync) state_d = RUN;

            if (accept) begin
                for (int i = 0; i < CH; i++) begin
                    if (slot_eff == SLOT_W'(i)) begin
                        ch_l_d[i] = bus.mux_left;
                        ch_r_d[i] = bus.mux_right;
                    end
                end
                slot_d = frame_last ? '0 : SLOT_W'(slot_eff + 1'b1);
            end else if (bus.sync) begin
                slot_d = '0;
            end

            if (partial && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            slot_q    <= '0;
            sample_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < CH; i++) begin
                ch_l_q[i] <= '0;
                ch_r_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            sample_q  <= sample_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            ch_l_q    <= ch_l_d;
            ch_r_q    <= ch_r_d;
        end
    end

    jt12_mux_acc #(.IW(W), .AW(OW)) u_acc_l (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .clear  (bus.sync),
        .add    (accept),
        .last   (frame_last),
        .mute   (mute_bit),
        .word   (bus.mux_left),
        .mix    (bus.left)
    );

    jt12_mux_acc #(.IW(W), .AW(OW)) u_acc_r (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .clear  (bus.sync),
        .add    (accept),
        .last   (frame_last),
        .mute   (mute_bit),
        .word   (bus.mux_right),
        .mix    (bus.right)
    );

    always_comb begin
        ch_left  = '0;
        ch_right = '0;
        for (int i = 0; i < CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                ch_left  = ch_l_q[i];
                ch_right = ch_r_q[i];
            end
        end
    end

    assign bus.sample = sample_q;
    assign locked     = (state_q == RUN);
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_jt12_mux_demux.sv
// ----------------------------------------------------------------------------
// tb_jt12_mux_demux
// Self-checking bench for the multiplexed-DAC receiver. Frame results are
// pushed to a scoreboard when the last word is driven and popped when the
// DUT pulses sample.
// ----------------------------------------------------------------------------
module tb_jt12_mux_demux;
    import jt12_mux_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic [CH-1:0]     mute;
    logic [SEL_W-1:0]  ch_sel;
    logic [W-1:0]      ch_left;
    logic [W-1:0]      ch_right;
    logic              locked;
    logic              err;
    logic [ERRW-1:0]   err_cnt;

    jt12_mux_demux_if bus_if ();

    always #5 clk = ~clk;

    jt12_mux_demux dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .bus      (bus_if.slave),
        .mute     (mute),
        .ch_sel   (ch_sel),
        .ch_left  (ch_left),
        .ch_right (ch_right),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int l;
        int r;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [5:0][8:0] l;
        logic [5:0][8:0] r;
        logic [5:0]      mute;
        logic [2:0]      rb_sel;
        int              exp_l;
        int              exp_r;
        int              exp_rb_l;
        int              exp_rb_r;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [8:0] l, input logic [8:0] r, input logic s);
        bus_if.mux_left   = l;
        bus_if.mux_right  = r;
        bus_if.mux_sample = 1'b1;
        bus_if.sync       = s;
        step();
        bus_if.mux_sample = 1'b0;
        bus_if.sync       = 1'b0;
    endtask

    task automatic sync_pulse();
        bus_if.sync = 1'b1;
        step();
        bus_if.sync = 1'b0;
    endtask

    task automatic push(input int l, input int r);
        exp_t e;
        e.l = l;
        e.r = r;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        check("drain_sample_seen", sb.size(), 0);
    endtask

    // Scoreboard consumer: every sample pulse must match a pushed frame result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus_if.sample === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sample_unexpected: got pulse, expected none");
            end else begin
                e = sb.pop_front();
                check("mix_left",  int'($signed(bus_if.left)),  e.l);
                check("mix_right", int'($signed(bus_if.right)), e.r);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            vecs[0].l[i] = 9'(i + 1);
            vecs[0].r[i] = 9'(-(i + 1));
            vecs[1].l[i] = 9'h100;
            vecs[1].r[i] = 9'h0FF;
            vecs[2].l[i] = 9'(10 * (i + 1));
            vecs[2].r[i] = 9'(i + 1);
            vecs[3].l[i] = 9'(-10);
            vecs[3].r[i] = 9'(100);
        end
        vecs[0].mute = 6'b000000; vecs[0].rb_sel = 3'd0;
        vecs[0].exp_l = 21;    vecs[0].exp_r = -21;  vecs[0].exp_rb_l = 1;    vecs[0].exp_rb_r = -1;
        vecs[1].mute = 6'b000000; vecs[1].rb_sel = 3'd5;
        vecs[1].exp_l = -1536; vecs[1].exp_r = 1530; vecs[1].exp_rb_l = -256; vecs[1].exp_rb_r = 255;
        vecs[2].mute = 6'b000100; vecs[2].rb_sel = 3'd2;
        vecs[2].exp_l = 180;   vecs[2].exp_r = 18;   vecs[2].exp_rb_l = 30;   vecs[2].exp_rb_r = 3;
        vecs[3].mute = 6'b100001; vecs[3].rb_sel = 3'd7;
        vecs[3].exp_l = -40;   vecs[3].exp_r = 400;  vecs[3].exp_rb_l = 0;    vecs[3].exp_rb_r = 0;

        rst               = 1'b1;
        clk_en            = 1'b1;
        mute              = '0;
        ch_sel            = '0;
        bus_if.sync       = 1'b0;
        bus_if.mux_sample = 1'b0;
        bus_if.mux_left   = '0;
        bus_if.mux_right  = '0;
        repeat (3) step();

        check("rst_left",    int'($signed(bus_if.left)),  0);
        check("rst_right",   int'($signed(bus_if.right)), 0);
        check("rst_sample",  int'(bus_if.sample), 0);
        check("rst_locked",  int'(locked), 0);
        check("rst_err",     int'(err), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        step();

        // Words before any sync are ignored.
        for (int i = 0; i < 3; i++) strobe(9'd50, 9'd50, 1'b0);
        check("hunt_locked",  int'(locked), 0);
        check("hunt_ch_left", int'($signed(ch_left)), 0);

        // Sync coinciding with a word: that word is slot 0.
        strobe(9'd7, 9'(-7), 1'b1);
        check("coinc_locked", int'(locked), 1);
        for (int i = 0; i < 4; i++) strobe(9'd1, 9'(-1), 1'b0);
        push(12, -12);
        strobe(9'd1, 9'(-1), 1'b0);
        drain();

        // Sync at a frame boundary is silent.
        sync_pulse();
        check("realign_err",     int'(err), 0);
        check("realign_err_cnt", int'(err_cnt), 0);

        for (int v = 0; v < 4; v++) begin
            mute = vecs[v].mute;
            for (int i = 0; i < 6; i++) begin
                if (i == 5) push(vecs[v].exp_l, vecs[v].exp_r);
                strobe(vecs[v].l[i], vecs[v].r[i], 1'b0);
            end
            drain();
            ch_sel = vecs[v].rb_sel;
            #1;
            check("rb_left",  int'($signed(ch_left)),  vecs[v].exp_rb_l);
            check("rb_right", int'($signed(ch_right)), vecs[v].exp_rb_r);
        end
        mute   = '0;
        ch_sel = '0;

        // Partial frame: discard, error pulse, outputs hold.
        for (int i = 0; i < 3; i++) strobe(9'd9, 9'd9, 1'b0);
        sync_pulse();
        check("partial_err",     int'(err), 1);
        check("partial_err_cnt", int'(err_cnt), 1);
        check("partial_left",    int'($signed(bus_if.left)),  -40);
        check("partial_right",   int'($signed(bus_if.right)), 400);
        step();
        check("partial_err_end", int'(err), 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) push(30, 30);
            strobe(9'd5, 9'd5, 1'b0);
        end
        drain();

        // clk_en low: strobes and a mid-frame sync are ignored.
        for (int i = 0; i < 6; i++) begin
            clk_en = 1'b0;
            strobe(9'd100, 9'd100, 1'b0);
            if (i == 3) sync_pulse();
            clk_en = 1'b1;
            if (i == 5) push(12, -12);
            strobe(9'd2, 9'(-2), 1'b0);
        end
        drain();
        check("gated_err_cnt", int'(err_cnt), 1);

        // Reset mid-frame.
        strobe(9'd3, 9'd3, 1'b0);
        strobe(9'd3, 9'd3, 1'b0);
        rst = 1'b1;
        step();
        check("mrst_left",    int'($signed(bus_if.left)),  0);
        check("mrst_right",   int'($signed(bus_if.right)), 0);
        check("mrst_locked",  int'(locked), 0);
        check("mrst_err_cnt", int'(err_cnt), 0);
        check("mrst_ch_left", int'($signed(ch_left)), 0);
        rst = 1'b0;
        step();

        // Error counter saturation.
        sync_pulse();
        for (int k = 1; k <= 300; k++) begin
            strobe(9'd1, 9'd1, 1'b0);
            sync_pulse();
            if (k == 255) check("sat_err_cnt_255", int'(err_cnt), 255);
        end
        check("sat_err_cnt_300", int'(err_cnt), 255);

        step();
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
